// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-side responder.
package mem_responder_pkg;

    typedef logic [31:0] rv32i_word;

    localparam int unsigned MEM_LATENCY_DEFAULT = 3;
    localparam int unsigned CNT_W               = 4;
    localparam int unsigned BE_W                = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    // Request fields captured at acceptance; authoritative until the response.
    typedef struct packed {
        logic            write;
        logic [BE_W-1:0] byte_enable;
        rv32i_word       wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory single-port request/response bus.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic            mem_read;
    logic            mem_write;
    logic [BE_W-1:0] mem_byte_enable;
    logic [31:0]     mem_address;
    rv32i_word       mem_wdata;
    logic            mem_resp;
    rv32i_word       mem_rdata;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read port.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BE_W-1:0]   we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  rv32i_word         wdata,
    output rv32i_word         rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    rv32i_word mem [DEPTH];

    // Byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BE_W); i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register holds its value until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request, answers with a one-cycle mem_resp.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic            busy,
    output logic            protocol_err
);

    localparam bit FAST = (LATENCY == 1);

    mem_resp_state_t   state;
    logic [CNT_W-1:0]  count;
    mem_req_t          lat_req;
    logic [ADDR_W-1:0] lat_idx;

    logic              req_c;
    logic              access_c;
    logic              op_write_c;
    logic [ADDR_W-1:0] idx_c;
    logic [BE_W-1:0]   be_c;
    rv32i_word         wdata_c;
    logic [BE_W-1:0]   ram_we_c;
    logic              ram_re_c;
    logic              unused_addr_c;

    assign req_c = bus.mem_read | bus.mem_write;

    // With LATENCY=1 the access happens on the acceptance edge, so IDLE uses the live bus.
    assign access_c = !rst &&
                      (((state == IDLE) && req_c && FAST) ||
                       ((state == WAIT) && req_c && (count == CNT_W'(1))));

    assign op_write_c = (state == IDLE) ? bus.mem_write       : lat_req.write;
    assign idx_c      = (state == IDLE) ? bus.mem_address[ADDR_W+1:2] : lat_idx;
    assign be_c       = (state == IDLE) ? bus.mem_byte_enable : lat_req.byte_enable;
    assign wdata_c    = (state == IDLE) ? bus.mem_wdata       : lat_req.wdata;

    assign ram_we_c = (access_c && op_write_c) ? be_c : '0;
    assign ram_re_c = access_c && !op_write_c;

    // Upper address bits alias and the byte offset is ignored.
    assign unused_addr_c = ^{bus.mem_address[31:ADDR_W+2], bus.mem_address[1:0]};

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_c),
        .re    (ram_re_c),
        .addr  (idx_c),
        .wdata (wdata_c),
        .rdata (bus.mem_rdata)
    );

    // Request FSM with registered mem_resp / busy / protocol_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            bus.mem_resp <= 1'b0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
            lat_req      <= '0;
            lat_idx      <= '0;
        end else begin
            bus.mem_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_c) begin
                        lat_req.write       <= bus.mem_write;
                        lat_req.byte_enable <= bus.mem_byte_enable;
                        lat_req.wdata       <= bus.mem_wdata;
                        lat_idx             <= bus.mem_address[ADDR_W+1:2];
                        busy                <= 1'b1;
                        if (bus.mem_read && bus.mem_write) begin
                            protocol_err <= 1'b1;
                        end
                        if (FAST) begin
                            state        <= RESP;
                            count        <= '0;
                            bus.mem_resp <= 1'b1;
                        end else begin
                            state <= WAIT;
                            count <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!req_c) begin
                        // Request withdrawn mid-flight: drop it and flag the violation.
                        state        <= IDLE;
                        count        <= '0;
                        busy         <= 1'b0;
                        protocol_err <= 1'b1;
                    end else if (count == CNT_W'(1)) begin
                        state        <= RESP;
                        count        <= '0;
                        bus.mem_resp <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=3 instance for data paths, LATENCY=1 for held requests.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          exp_cyc;
        logic [31:0] exp_rdata;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hold_rd = 32'h0;

    mem_responder_if bus3 ();
    mem_responder_if bus1 ();
    logic busy3, err3, busy1, err1;

    mem_responder #(.ADDR_W(10), .LATENCY(LAT)) u3 (
        .clk(clk), .rst(rst), .bus(bus3), .busy(busy3), .protocol_err(err3)
    );

    mem_responder #(.ADDR_W(10), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .protocol_err(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle3();
        bus3.mem_read = 1'b0; bus3.mem_write = 1'b0;
        bus3.mem_byte_enable = 4'h0; bus3.mem_address = 32'h0; bus3.mem_wdata = 32'h0;
    endtask

    // Issue one request on the LATENCY=3 port, push its expectation, hold until mem_resp.
    task automatic do_req(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rd);
        exp_t e;
        int   n;
        @(negedge clk);
        bus3.mem_read = rd; bus3.mem_write = wr;
        bus3.mem_address = addr; bus3.mem_wdata = wdata; bus3.mem_byte_enable = be;
        e.exp_cyc   = cyc + LAT;
        e.exp_rdata = wr ? hold_rd : exp_rd;
        e.name      = name;
        if (!wr) hold_rd = exp_rd;
        sb.push_back(e);
        @(negedge clk);
        check({name, "_busy"}, 32'(busy3), 32'd1);
        n = 0;
        while (bus3.mem_resp !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no mem_resp want mem_resp", name);
        end
        idle3();
    endtask

    task automatic count_pulses(input string name, input int cycles);
        int pulses;
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus3.mem_resp === 1'b1) pulses++;
        end
        check(name, 32'(pulses), 32'd0);
    endtask

    // Monitor: every mem_resp pops one expectation and checks latency and data.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus3.mem_resp === 1'b1) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_resp: got pulse at cycle %0d want none", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_lat"}, 32'(cyc), 32'(e.exp_cyc));
                    check({e.name, "_rdata"}, bus3.mem_rdata, e.exp_rdata);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin : stim
        idle3();
        bus1.mem_read = 1'b0; bus1.mem_write = 1'b0;
        bus1.mem_byte_enable = 4'h0; bus1.mem_address = 32'h0; bus1.mem_wdata = 32'h0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_resp",  32'(bus3.mem_resp), 32'd0);
        check("rst_rdata", bus3.mem_rdata,     32'h0);
        check("rst_busy",  32'(busy3),         32'd0);
        check("rst_err",   32'(err3),          32'd0);
        rst = 1'b0;

        do_req("wr_full",  1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0);
        do_req("rd_full",  1'b1, 1'b0, 32'h40, 32'h0,        4'h0, 32'hDEADBEEF);
        do_req("wr_lane0", 1'b0, 1'b1, 32'h40, 32'h000000AA, 4'h1, 32'h0);
        do_req("rd_lane0", 1'b1, 1'b0, 32'h40, 32'h0,        4'hF, 32'hDEADBEAA);
        do_req("wr_be0",   1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 32'h0);
        do_req("rd_be0",   1'b1, 1'b0, 32'h40, 32'h0,        4'h0, 32'hDEADBEAA);
        do_req("wr_alias", 1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0);
        do_req("rd_alias", 1'b1, 1'b0, 32'h0,  32'h0,        4'h0, 32'hCAFEF00D);
        do_req("wr_80",    1'b0, 1'b1, 32'h80, 32'h0,        4'hF, 32'h0);
        do_req("wr_10",    1'b0, 1'b1, 32'h10, 32'h5555AAAA, 4'hF, 32'h0);
        check("no_err_yet", 32'(err3), 32'd0);

        // Write withdrawn one cycle after acceptance.
        @(negedge clk);
        bus3.mem_write = 1'b1; bus3.mem_address = 32'h80;
        bus3.mem_wdata = 32'h12345678; bus3.mem_byte_enable = 4'hF;
        @(negedge clk);
        idle3();
        count_pulses("abort_resp_count", 8);
        check("abort_err",  32'(err3),  32'd1);
        check("abort_busy", 32'(busy3), 32'd0);
        do_req("rd_abort", 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 32'h0);

        // Reset during the second WAIT cycle of a write.
        @(negedge clk);
        bus3.mem_write = 1'b1; bus3.mem_address = 32'h10;
        bus3.mem_wdata = 32'hFFFFFFFF; bus3.mem_byte_enable = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle3();
        @(negedge clk);
        check("midrst_busy",  32'(busy3),         32'd0);
        check("midrst_resp",  32'(bus3.mem_resp), 32'd0);
        check("midrst_rdata", bus3.mem_rdata,     32'h0);
        check("midrst_err",   32'(err3),          32'd0);
        rst = 1'b0;
        hold_rd = 32'h0;
        count_pulses("midrst_resp_count", 6);
        do_req("rd_midrst", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h5555AAAA);

        // Read and write both asserted: handled as a write.
        do_req("wr_both", 1'b1, 1'b1, 32'h10, 32'h01020304, 4'hF, 32'h0);
        check("both_err", 32'(err3), 32'd1);
        do_req("rd_both", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h01020304);

        // LATENCY=1 held read: one-cycle pulse every second cycle.
        @(negedge clk);
        bus1.mem_read = 1'b1; bus1.mem_address = 32'h20;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("held_resp_%0d", k), 32'(bus1.mem_resp), 32'(k % 2));
        end
        bus1.mem_read = 1'b0;
        check("held_err", 32'(err1), 32'd0);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
